// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
// Optional signed-overflow output is enabled with `SERIAL_ADDSUB_OVF_EN.
package serial_addsub_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Counter width able to hold nibbles-1, never narrower than one bit.
   function automatic int cnt_width(input int nibbles);
      return (nibbles > 1) ? $clog2(nibbles) : 1;
   endfunction

endpackage

// File: rtl/nibble_addsub_slice.sv
// Combinational 4-bit add slice; b arrives already inverted for subtract.
// Zero latency, no flow control.
module nibble_addsub_slice
   import serial_addsub_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] sum,
   output logic                cout
);

   logic [NIBBLE_W:0] total;

   assign total = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
   assign sum   = total[NIBBLE_W-1:0];
   assign cout  = total[NIBBLE_W];

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Nibble-serial add/sub: result valid WIDTH/4 cycles after accept, held until res_ready.
// Start is only taken in IDLE; `SERIAL_ADDSUB_OVF_EN adds the signed overflow port.
module serial_addsub_ctrl
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             sub,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             res_valid,
   input  logic             res_ready,
`ifdef SERIAL_ADDSUB_OVF_EN
   output logic             overflow,
`endif
   output logic             busy
);

   localparam int NIBBLES = WIDTH / NIBBLE_W;
   localparam int CW      = cnt_width(NIBBLES);
   localparam logic [CW-1:0] LAST_CNT = CW'(NIBBLES - 1);

   generate
      if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
         $error("serial_addsub_ctrl: WIDTH must be a multiple of 4 and >= 8");
      end
   endgenerate

   state_t state;
   state_t state_nxt;

   logic [CW-1:0]          count;
   logic                   carry;
   logic [WIDTH-1:0]       a_sh;
   logic [WIDTH-1:0]       b_sh;
   logic [WIDTH-NIBBLE_W-1:0] acc;
   logic [WIDTH-1:0]       acc_nxt;
   logic [NIBBLE_W-1:0]    slice_sum;
   logic                   slice_cout;
   logic                   accept;
   logic                   last_nib;
   logic                   release_res;

   nibble_addsub_slice u_slice (
      .a    (a_sh[NIBBLE_W-1:0]),
      .b    (b_sh[NIBBLE_W-1:0]),
      .cin  (carry),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      accept      = 1'b0;
      last_nib    = 1'b0;
      release_res = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (count == LAST_CNT) begin
               last_nib  = 1'b1;
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (res_ready) begin
               release_res = 1'b1;
               state_nxt   = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign in_ready = (state == S_IDLE);
   assign busy     = (state == S_RUN);

   // New nibble enters at the top; earlier nibbles slide toward the LSB.
   assign acc_nxt = {slice_sum, acc};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count     <= '0;
         carry     <= 1'b0;
         a_sh      <= '0;
         b_sh      <= '0;
         acc       <= '0;
         result    <= '0;
         carry_out <= 1'b0;
         res_valid <= 1'b0;
      end else if (accept) begin
         a_sh      <= op_a;
         b_sh      <= op_b ^ {WIDTH{sub}};
         carry     <= sub;
         count     <= '0;
         res_valid <= 1'b0;
      end else if (state == S_RUN) begin
         a_sh  <= a_sh >> NIBBLE_W;
         b_sh  <= b_sh >> NIBBLE_W;
         acc   <= acc_nxt[WIDTH-1:NIBBLE_W];
         carry <= slice_cout;
         if (last_nib) begin
            result    <= acc_nxt;
            carry_out <= slice_cout;
            res_valid <= 1'b1;
         end else begin
            count <= count + CW'(1);
         end
      end else if (release_res) begin
         res_valid <= 1'b0;
      end
   end

`ifdef SERIAL_ADDSUB_OVF_EN
   // Sign bits of the top nibble decide two's-complement overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (last_nib) begin
         overflow <= (a_sh[NIBBLE_W-1] == b_sh[NIBBLE_W-1]) &&
                     (slice_sum[NIBBLE_W-1] != a_sh[NIBBLE_W-1]);
      end
   end
`endif

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Randomized and directed bench for serial_addsub_ctrl at WIDTH=16.
module tb_serial_addsub_ctrl;

   localparam int WIDTH = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic             in_ready;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             sub;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             res_valid;
   logic             res_ready;
   logic             busy;
`ifdef SERIAL_ADDSUB_OVF_EN
   logic             overflow;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .sub       (sub),
      .result    (result),
      .carry_out (carry_out),
      .res_valid (res_valid),
      .res_ready (res_ready),
`ifdef SERIAL_ADDSUB_OVF_EN
      .overflow  (overflow),
`endif
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction; noise drives start and fresh operands while the op is in flight.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input int hold, input bit noise);
      int unsigned exp_res;
      int          exp_c;
      int          sa, sb, sr;
      int          lat;
      exp_res = s ? ((32'(a) - 32'(b)) & 32'hFFFF) : ((32'(a) + 32'(b)) & 32'hFFFF);
      exp_c   = s ? int'(a >= b) : int'((32'(a) + 32'(b)) > 32'hFFFF);
      sa = int'($signed(a));
      sb = int'($signed(b));
      sr = s ? (sa - sb) : (sa + sb);

      check("idle_in_ready", 32'(in_ready), 32'd1);
      op_a = a; op_b = b; sub = s; start = 1'b1; res_ready = 1'b0;
      tick();
      start = 1'b0;
      check("accept_busy", 32'(busy), 32'd1);
      check("accept_in_ready", 32'(in_ready), 32'd0);
      lat = 0;
      while (!res_valid && lat < 20) begin
         if (noise) begin
            op_a = 16'($urandom); op_b = 16'($urandom); sub = 1'($urandom); start = 1'b1;
         end
         check("run_no_valid", 32'(res_valid), 32'd0);
         tick();
         lat++;
      end
      check("latency", 32'(lat), 32'd4);
      check("result", 32'(result), exp_res);
      check("carry_out", 32'(carry_out), 32'(exp_c));
      check("done_busy", 32'(busy), 32'd0);
`ifdef SERIAL_ADDSUB_OVF_EN
      check("overflow", 32'(overflow), 32'(sr < -32768 || sr > 32767));
`endif
      for (int i = 0; i < hold; i++) begin
         if (noise) begin
            op_a = 16'($urandom); op_b = 16'($urandom); start = 1'b1;
         end
         tick();
         check("hold_valid", 32'(res_valid), 32'd1);
         check("hold_result", 32'(result), exp_res);
         check("hold_in_ready", 32'(in_ready), 32'd0);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      start = 1'b0;
      check("release_in_ready", 32'(in_ready), 32'd1);
      check("release_valid", 32'(res_valid), 32'd0);
      check("release_keep_result", 32'(result), exp_res);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; sub = 1'b0; res_ready = 1'b0;
      repeat (2) tick();
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_valid", 32'(res_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_carry", 32'(carry_out), 32'd0);
      rst_n = 1'b1;
      tick();

      run_op(16'h1234, 16'h0FFF, 1'b0, 0, 1'b0);
      run_op(16'h0007, 16'h0005, 1'b1, 0, 1'b0);
      run_op(16'h0005, 16'h0007, 1'b1, 0, 1'b0);
      run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
      run_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
      run_op(16'h8000, 16'h0001, 1'b1, 3, 1'b1);
      run_op(16'hABCD, 16'h1111, 1'b0, 1, 1'b1);

      // Abort mid-RUN: reset must clear everything at once.
      op_a = 16'h4321; op_b = 16'h1234; sub = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("abort_in_ready", 32'(in_ready), 32'd1);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_valid", 32'(res_valid), 32'd0);
      check("abort_result", 32'(result), 32'd0);
      check("abort_carry", 32'(carry_out), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      run_op(16'h0100, 16'h00FF, 1'b1, 0, 1'b0);

      for (int k = 0; k < 40; k++) begin
         run_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                1'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
